// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: the glyph table used by both the display
// encoder and the switch reader, plus the reader FSM state type.
package sevenseg_pkg;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Table indexed by hex value: GLYPH_TABLE[v] is the glyph for digit v
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    EMIT     = 2'd2,
    WAIT_CHG = 2'd3
  } state_e;

endpackage

// File: rtl/sevenseg_lookup.sv
// Combinational reverse lookup: segment pattern -> {hit, hex value}.
module sevenseg_lookup
  import sevenseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] value
);

  // Glyphs are unique, so at most one table entry can match
  always_comb begin
    hit   = 1'b0;
    value = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPH_TABLE[i]) begin
        hit   = 1'b1;
        value = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sevenseg_reader.sv
// Switch-entered seven-segment reader: synchronize, debounce, decode and
// hand one result per stable non-blank pattern to the consumer.
module sevenseg_reader
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic [3:0] value,
  output logic       err,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       s1_q, s1_d, s2_q, s2_d, p_q, p_d, e_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q;
  logic [3:0]       value_q;
  logic             err_q, valid_q, busy_q;

  logic             changed, settled, lk_hit;
  logic [3:0]       lk_value;

  assign changed = (s2_q != p_q);
  assign settled = !changed && (cnt_q == CNT_MAX);

  sevenseg_lookup u_lookup (
    .pattern (p_q),
    .hit     (lk_hit),
    .value   (lk_value)
  );

  // Sampling path: two-flop sync, then last-pattern register with a
  // saturating stability count that restarts on every change
  always_comb begin
    s1_d  = seg_in;
    s2_d  = s1_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    if (changed) begin
      p_d   = s2_q;
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Sampling registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= SEG_BLANK;
      s2_q  <= SEG_BLANK;
      p_q   <= SEG_BLANK;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
    end
  end

  // Control FSM with registered outputs; e_q remembers the last emitted
  // pattern so a held pattern is never reported twice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      e_q     <= SEG_BLANK;
      value_q <= 4'h0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (changed) begin
            state_q <= SETTLE;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (settled) begin
            if (p_q == SEG_BLANK) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= EMIT;
              e_q     <= p_q;
              value_q <= lk_hit ? lk_value : 4'h0;
              err_q   <= !lk_hit;
              valid_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          // Outputs frozen until accepted; p/cnt keep tracking meanwhile
          if (ready) begin
            state_q <= WAIT_CHG;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        WAIT_CHG: begin
          if (p_q != e_q) begin
            state_q <= SETTLE;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign value = value_q;
  assign err   = err_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Randomized scoreboard bench for sevenseg_reader.
module tb_sevenseg_reader;

  localparam int         S     = 4;
  localparam int         LONG  = 16;
  localparam logic [6:0] BLANK = 7'b1111111;

  // Glyph table written out independently of the design package
  localparam logic [6:0] REF_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [3:0] value;
    logic       err;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = BLANK;
  logic       ready = 1'b0;
  logic [3:0] value;
  logic       err, valid, busy;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   ready_mode = 1;  // 0 random (forced after a short stall), 1 always, 2 never
  logic busy_at4 = 1'b0;

  // Model of which held runs produce a result
  logic [6:0] m_pat = BLANK;
  int         m_run = 0;
  bit         m_done = 1'b1;

  always #5 clk = ~clk;

  sevenseg_reader #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seg_in (seg_in),
    .value  (value),
    .err    (err),
    .valid  (valid),
    .ready  (ready),
    .busy   (busy)
  );

  function automatic res_t ref_decode(input logic [6:0] p);
    res_t r;
    r.value = 4'h0;
    r.err   = 1'b1;
    for (int i = 0; i < 16; i++)
      if (p == REF_TAB[i]) begin
        r.value = 4'(i);
        r.err   = 1'b0;
      end
    return r;
  endfunction

  // A maximal run of one pattern held >= LONG cycles yields one result
  // unless blank; runs of at most S cycles yield nothing
  task automatic model_step(input logic [6:0] pat, input int n);
    if (pat !== m_pat) begin
      m_pat  = pat;
      m_run  = 0;
      m_done = 1'b0;
    end
    m_run += n;
    if (!m_done && m_run >= LONG) begin
      m_done = 1'b1;
      if (pat != BLANK) exp_q.push_back(ref_decode(pat));
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Hold pat for n edges; report the first edge (1-based) at which valid is seen
  task automatic drive(input logic [6:0] pat, input int n, output int first_v);
    model_step(pat, n);
    seg_in  = pat;
    first_v = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1 && first_v == 0) first_v = k;
      if (k == 4) busy_at4 = busy;
    end
  endtask

  // Consumer ready generator
  initial begin : ready_gen
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) wcnt++;
      else wcnt = 0;
      case (ready_mode)
        1:       ready = 1'b1;
        2:       ready = 1'b0;
        default: ready = (wcnt >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops on each transfer and checks output stability while stalled
  initial begin : monitor
    res_t       e;
    logic       hp;
    logic [3:0] pv;
    logic       pe;
    hp = 1'b0;
    pv = 4'h0;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hp = 1'b0;
      end else begin
        if (hp) begin
          n_checks++;
          if (valid !== 1'b1 || value !== pv || err !== pe) begin
            n_fail++;
            $display("FAIL hold_stable: got valid=%b value=%h err=%b, required valid=1 value=%h err=%b",
                     valid, value, err, pv, pe);
          end
        end
        if (valid === 1'b1 && ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got value=%h err=%b, required no result", value, err);
          end else begin
            e = exp_q.pop_front();
            check("result_value", 32'(value), 32'(e.value));
            check("result_err", 32'(err), 32'(e.err));
          end
        end
        hp = (valid === 1'b1) && (ready !== 1'b1);
        pv = value;
        pe = err;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         fv;
    logic [6:0] pat;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_err",   32'(err),   32'd0);
    check("reset_value", 32'(value), 32'd0);
    rst_n = 1'b1;

    // Blank after reset never produces a result
    ready_mode = 1;
    drive(BLANK, 30, fv);
    check("blank_no_valid", 32'(fv), 32'd0);

    // Digit 2 held: single pulse at edge S+3, busy while settling
    drive(REF_TAB[2], 30, fv);
    check("latency_2", 32'(fv), 32'(S + 3));
    check("busy_settle", 32'(busy_at4), 32'd1);

    // Stall on F, change to 1 during the stall, then release
    drive(BLANK, 20, fv);
    ready_mode = 2;
    drive(REF_TAB[15], 20, fv);
    check("stall_valid", 32'(valid), 32'd1);
    check("stall_value", 32'(value), 32'hF);
    drive(REF_TAB[1], 10, fv);
    check("stall_value_after_change", 32'(value), 32'hF);
    ready_mode = 0;
    drive(REF_TAB[1], 20, fv);

    // Glitching 8 <-> 9 then settling on 9
    ready_mode = 1;
    drive(BLANK, 20, fv);
    for (int i = 0; i < 5; i++) begin
      drive(REF_TAB[8], 2, fv);
      drive(REF_TAB[9], 2, fv);
    end
    drive(REF_TAB[8], 2, fv);
    drive(REF_TAB[9], 20, fv);
    check("glitch_latency", 32'(fv), 32'(S + 3));

    // Illegal pattern
    drive(BLANK, 20, fv);
    drive(7'b0101010, 20, fv);

    // Walk all glyphs with blanks in between, random ready
    ready_mode = 0;
    for (int g = 0; g < 16; g++) begin
      drive(BLANK, 20, fv);
      drive(REF_TAB[g], 20, fv);
    end

    // Random patterns with short glitches
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       pat = BLANK;
        1:       pat = REF_TAB[$urandom_range(0, 15)];
        default: pat = 7'($urandom);
      endcase
      drive(pat, LONG + 4 + $urandom_range(0, 8), fv);
      if ($urandom_range(0, 1) == 1)
        drive(7'($urandom), $urandom_range(1, S - 1), fv);
    end

    // Reset while a result is pending
    ready_mode = 2;
    drive(BLANK, 20, fv);
    drive(REF_TAB[6], 20, fv);
    check("pre_reset_valid", 32'(valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(valid), 32'd0);
    check("async_reset_busy",  32'(busy),  32'd0);
    check("async_reset_err",   32'(err),   32'd0);
    exp_q.delete();
    m_pat  = BLANK;
    m_run  = 0;
    m_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 1;
    drive(REF_TAB[6], 20, fv);
    check("post_reset_latency", 32'(fv), 32'(S + 3));
    drive(BLANK, 20, fv);

    // Drain
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_reader.md
# sevenseg_reader

Reverse path of the hex-to-segment display encoder: samples a 7-bit active-low segment pattern entered by the trainee on switches, synchronizes and debounces it, and decodes it back to a 4-bit hex value. Each stable, non-blank pattern produces one result, delivered over a valid/ready handshake to the trainer scoring logic. Patterns that are not a legal 0–F glyph are reported with an error flag.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before decode; legal range 1–255.
- CNT_W, 8: stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seg_in  in  7  raw segment pattern, bit order {g,f,e,d,c,b,a}, 0 = segment lit; asynchronous to clk.
- value  out  4  decoded hex digit; 4'h0 when err = 1.
- err  out  1  qualifies value: pattern is not a legal glyph.
- valid  out  1  result available; held until accepted.
- ready  in  1  consumer accepts the result when valid & ready.
- busy  out  1  high in SETTLE or EMIT.

## Operation
- Glyph table (value: pattern):
  - 0: 1000000; 1: 1111001; 2: 0100100; 3: 0110000
  - 4: 0011001; 5: 0010010; 6: 0000010; 7: 1111000
  - 8: 0000000; 9: 0011000; A: 0001000; b: 0000011
  - C: 1000110; d: 0100001; E: 0000110; F: 0001110
- Blank = 1111111.
- Two-flop synchronizer s1→s2 on seg_in; a third register p holds the last sampled pattern.
- Every cycle: if s2 ≠ p, then p ← s2 and cnt ← 0; otherwise cnt saturates at STABLE_CYCLES-1.
- FSM states:
  - IDLE: on s2 ≠ p → SETTLE.
  - SETTLE: any change restarts the count. At cnt = STABLE_CYCLES-1 with no change:
    - p is blank → IDLE, no emission.
    - p matches a glyph → EMIT with value = glyph, err = 0.
    - otherwise → EMIT with value = 0, err = 1.
    - The emitted pattern is stored in e.
  - EMIT: valid = 1; value and err frozen; seg_in changes are tracked in p/cnt but do not alter the outputs. On valid & ready → WAIT_CHG.
  - WAIT_CHG: stays until p ≠ e, then → SETTLE. Holding one pattern never produces a second result.
- Reset values: s1 = s2 = p = e = 7'h7F, cnt = 0, state IDLE. All outputs are 0: value = 0, err = 0, valid = 0, busy = 0.

## Timing
- Outputs are registered; there is no combinational path from seg_in or ready to any output.
- Latency: seg_in changes and then stays constant; valid rises on the (STABLE_CYCLES+3)-th rising edge after the first edge that captures the new value (2 sync + STABLE_CYCLES count + 1 output register).
- A change of seg_in within the window restarts the latency from that change.
- Handshake: valid, value and err are stable while valid & !ready. Valid deasserts on the edge after acceptance.
- ready asserted in the same cycle valid rises is accepted in that cycle (single-cycle transfer).
- ready while valid = 0 is ignored.
- Simultaneous seg_in change and acceptance: acceptance wins. The change is seen in WAIT_CHG (p ≠ e), giving → SETTLE one cycle later.
- Blank → glyph → blank sequences emit only the glyph.
- Reset asserted mid-operation: all state clears immediately (async). First valid after release follows the full latency.
- STABLE_CYCLES = 1: decode occurs on the cycle after p updates.

## Structure
- Package sevenseg_pkg:
  - 16 glyph constants and SEG_BLANK.
  - FSM state enum {IDLE, SETTLE, EMIT, WAIT_CHG}.
  - Shared with the display encoder so both directions use one table.
- Sub-module sevenseg_lookup: combinational, 7-bit pattern → {hit, value[3:0]}. Instantiated once on p.
- Top sevenseg_reader contains the synchronizer, counter, FSM and output registers.

## Test plan
- Reset, then seg_in = 0100100 held, ready = 1, STABLE_CYCLES = 4 → single valid pulse on edge 7 with value = 2, err = 0. No further pulses while held.
- seg_in = 0001110, ready = 0 for 10 cycles, seg_in changed to 1111001 during the stall → valid, value = F held constant until ready. After acceptance, a second result with value = 1 follows.
- Glitch: seg_in toggles 0000000 ↔ 0011000 every 2 cycles, then settles at 0011000 → no valid until 4 stable cycles, then one result with value = 9.
- Illegal pattern 0101010 held → valid with err = 1, value = 0. Blank 1111111 after reset → no valid ever.
- Walk all 16 glyphs with blank between each, ready random → 16 results in order 0..F, none with err = 1.
- rst_n pulled low while valid = 1 → valid, busy and err drop asynchronously. After release, the held pattern re-decodes after full latency.
